// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the per-subsystem reset sequencer.
package reset_seq_pkg;

  // Widest supported sequence; also sets the width of fault_stage and stage_idx.
  localparam int unsigned MAX_STAGES = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2,
    StFault   = 2'd3
  } seq_state_e;

  // Cause of the most recent sequence start.
  localparam logic [1:0] RC_POR   = 2'b01;
  localparam logic [1:0] RC_SW    = 2'b10;
  localparam logic [1:0] RC_FAULT = 2'b11;

  // Index of the lowest zero bit; returns 0 if every bit is set.
  function automatic logic [2:0] lowest_zero(input logic [MAX_STAGES-1:0] ack);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (!ack[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Stage-side signals of the reset sequencer: requests and acks in, resets and status out.
interface reset_sequencer_if #(
  parameter int unsigned N_STAGES = 4
);

  logic                sw_rst_req;
  logic [N_STAGES-1:0] stage_ack;
  logic [N_STAGES-1:0] stage_reset;
  logic                ready;
  logic                fault;
  logic [2:0]          fault_stage;
  logic [1:0]          rst_cause;

  // The sequencer itself.
  modport master (
    input  sw_rst_req,
    input  stage_ack,
    output stage_reset,
    output ready,
    output fault,
    output fault_stage,
    output rst_cause
  );

  // Subsystems and the software/host side.
  modport slave (
    output sw_rst_req,
    output stage_ack,
    input  stage_reset,
    input  ready,
    input  fault,
    input  fault_stage,
    input  rst_cause
  );

endinterface

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets in order, waiting for each stage's ack, and flags
// ack timeouts during sequencing and ack loss once running.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  reset_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       LastStage   = 3'(N_STAGES - 1);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          stage_idx_q, stage_idx_d;
  logic [N_STAGES-1:0] stage_reset_q, stage_reset_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;
  logic [2:0]          fault_stage_q, fault_stage_d;
  logic [1:0]          rst_cause_q, rst_cause_d;

  logic [MAX_STAGES-1:0] ack_pad;
  logic                  ack_cur;
  logic                  gap_done;
  logic                  all_acked;

  // Pad acks to the full width with ones so unused stages never look lost.
  always_comb begin
    ack_pad                 = '1;
    ack_pad[N_STAGES-1:0]   = bus.stage_ack;
  end

  assign ack_cur   = ack_pad[stage_idx_q];
  assign gap_done  = (cnt_q >= GapLast);
  assign all_acked = &bus.stage_ack;

  // Next state, stage index and sticky status fields.
  always_comb begin
    state_d       = state_q;
    stage_idx_d   = stage_idx_q;
    fault_stage_d = fault_stage_q;
    rst_cause_d   = rst_cause_q;

    if (bus.sw_rst_req) begin
      state_d     = StHold;
      stage_idx_d = '0;
      rst_cause_d = (state_q == StFault) ? RC_FAULT : RC_SW;
    end else begin
      case (state_q)
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_d     = StRelease;
            stage_idx_d = '0;
          end
        end
        StRelease: begin
          // Ack is only looked at once the gap has elapsed, so short pulses are dropped.
          if (gap_done && ack_cur) begin
            if (stage_idx_q == LastStage) begin
              state_d = StRun;
            end else begin
              stage_idx_d = stage_idx_q + 3'd1;
            end
          end else if (cnt_q == TimeoutLast) begin
            state_d       = StFault;
            fault_stage_d = stage_idx_q;
          end
        end
        StRun: begin
          if (!all_acked) begin
            state_d       = StFault;
            fault_stage_d = lowest_zero(ack_pad);
          end
        end
        StFault: begin
          // Only sw_rst_req or reset leave this state.
        end
        default: begin
          state_d = StHold;
        end
      endcase
    end
  end

  // Cycle counter: cleared on any state/stage change or restart, saturating otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.sw_rst_req || (state_d != state_q) || (stage_idx_d != stage_idx_q)) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs decoded from the next state so they are registered alongside it.
  always_comb begin
    stage_reset_d = '1;
    ready_d       = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      StRelease: begin
        for (int unsigned j = 0; j < N_STAGES; j++) begin
          stage_reset_d[j] = (3'(j) > stage_idx_d);
        end
      end
      StRun: begin
        stage_reset_d = '0;
        ready_d       = 1'b1;
      end
      StFault: begin
        fault_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHold;
      cnt_q         <= '0;
      stage_idx_q   <= '0;
      stage_reset_q <= '1;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
      rst_cause_q   <= RC_POR;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_idx_q   <= stage_idx_d;
      stage_reset_q <= stage_reset_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
      rst_cause_q   <= rst_cause_d;
    end
  end

  assign bus.stage_reset = stage_reset_q;
  assign bus.ready       = ready_q;
  assign bus.fault       = fault_q;
  assign bus.fault_stage = fault_stage_q;
  assign bus.rst_cause   = rst_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

  logic clk;
  logic reset;

  int n_total;
  int n_bad;

  reset_sequencer_if #(.N_STAGES(4)) sif ();

  reset_sequencer #(
    .N_STAGES   (4),
    .HOLD_CYCLES(16),
    .STAGE_GAP  (8),
    .TIMEOUT    (64),
    .CNT_W      (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges; outputs are settled and inputs may be driven on return.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for n edges; the next tick is edge 1 of the sequence.
  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    reset          = 1'b0;
    sif.sw_rst_req = 1'b0;
    sif.stage_ack  = 4'hF;

    // 1. Power-on with acks tied high.
    do_reset(3);
    check("por_stage_reset", 32'(sif.stage_reset), 32'hF);
    check("por_ready", 32'(sif.ready), 32'h0);
    check("por_fault", 32'(sif.fault), 32'h0);
    check("por_fault_stage", 32'(sif.fault_stage), 32'h0);
    check("por_cause", 32'(sif.rst_cause), 32'h1);
    tick(15);
    check("s1_e15", 32'(sif.stage_reset), 32'hF);
    tick(1);
    check("s1_e16", 32'(sif.stage_reset), 32'hE);
    tick(7);
    check("s1_e23", 32'(sif.stage_reset), 32'hE);
    tick(1);
    check("s1_e24", 32'(sif.stage_reset), 32'hC);
    tick(8);
    check("s1_e32", 32'(sif.stage_reset), 32'h8);
    tick(8);
    check("s1_e40", 32'(sif.stage_reset), 32'h0);
    check("s1_e40_ready", 32'(sif.ready), 32'h0);
    tick(7);
    check("s1_e47_ready", 32'(sif.ready), 32'h0);
    tick(1);
    check("s1_e48_ready", 32'(sif.ready), 32'h1);
    check("s1_cause", 32'(sif.rst_cause), 32'h1);
    check("s1_fault", 32'(sif.fault), 32'h0);

    // 2. Early ack pulse is dropped; slow ack on stage 1.
    sif.stage_ack = 4'b1100;
    do_reset(1);
    tick(18);
    sif.stage_ack[0] = 1'b1;
    tick(1);
    sif.stage_ack[0] = 1'b0;
    tick(5);
    check("s2_pulse_dropped", 32'(sif.stage_reset), 32'hE);
    tick(3);
    sif.stage_ack[0] = 1'b1;
    tick(1);
    check("s2_e28", 32'(sif.stage_reset), 32'hC);
    tick(30);
    check("s2_e58", 32'(sif.stage_reset), 32'hC);
    sif.stage_ack[1] = 1'b1;
    tick(1);
    check("s2_e59", 32'(sif.stage_reset), 32'h8);
    check("s2_fault", 32'(sif.fault), 32'h0);
    tick(16);
    check("s2_ready", 32'(sif.ready), 32'h1);

    // 5. Software restart in the middle of RELEASE(1).
    sif.stage_ack = 4'hF;
    do_reset(1);
    tick(24);
    check("s5_e24", 32'(sif.stage_reset), 32'hC);
    tick(2);
    sif.sw_rst_req = 1'b1;
    tick(1);
    sif.sw_rst_req = 1'b0;
    check("s5_restart_reset", 32'(sif.stage_reset), 32'hF);
    check("s5_cause", 32'(sif.rst_cause), 32'h2);
    check("s5_fault", 32'(sif.fault), 32'h0);
    tick(15);
    check("s5_e42", 32'(sif.stage_reset), 32'hF);
    tick(1);
    check("s5_e43", 32'(sif.stage_reset), 32'hE);
    tick(31);
    check("s5_e74_ready", 32'(sif.ready), 32'h0);
    tick(1);
    check("s5_e75_ready", 32'(sif.ready), 32'h1);

    // 3. Stage 2 never acks.
    sif.stage_ack = 4'b1011;
    do_reset(1);
    tick(32);
    check("s3_e32", 32'(sif.stage_reset), 32'h8);
    tick(63);
    check("s3_e95_reset", 32'(sif.stage_reset), 32'h8);
    check("s3_e95_fault", 32'(sif.fault), 32'h0);
    tick(1);
    check("s3_e96_reset", 32'(sif.stage_reset), 32'hF);
    check("s3_e96_fault", 32'(sif.fault), 32'h1);
    check("s3_fault_stage", 32'(sif.fault_stage), 32'h2);
    check("s3_ready", 32'(sif.ready), 32'h0);

    // 4. Restart from fault, then lose an ack while running.
    sif.stage_ack  = 4'hF;
    sif.sw_rst_req = 1'b1;
    tick(1);
    sif.sw_rst_req = 1'b0;
    check("s4_cause", 32'(sif.rst_cause), 32'h3);
    check("s4_fault_cleared", 32'(sif.fault), 32'h0);
    check("s4_hold_reset", 32'(sif.stage_reset), 32'hF);
    tick(47);
    check("s4_ready_47", 32'(sif.ready), 32'h0);
    tick(1);
    check("s4_ready_48", 32'(sif.ready), 32'h1);
    check("s4_run_reset", 32'(sif.stage_reset), 32'h0);
    sif.stage_ack[3] = 1'b0;
    tick(1);
    sif.stage_ack = 4'hF;
    check("s4_lost_fault", 32'(sif.fault), 32'h1);
    check("s4_lost_stage", 32'(sif.fault_stage), 32'h3);
    check("s4_lost_reset", 32'(sif.stage_reset), 32'hF);
    check("s4_lost_ready", 32'(sif.ready), 32'h0);
    tick(5);
    check("s4_fault_sticky", 32'(sif.fault), 32'h1);
    sif.sw_rst_req = 1'b1;
    tick(1);
    sif.sw_rst_req = 1'b0;
    check("s4_cause2", 32'(sif.rst_cause), 32'h3);
    tick(48);
    check("s4_ready2", 32'(sif.ready), 32'h1);
    sif.stage_ack = 4'b0101;
    tick(1);
    sif.stage_ack = 4'hF;
    check("s4_lowest_stage", 32'(sif.fault_stage), 32'h1);

    // 6. reset and sw_rst_req together from FAULT: reset wins.
    reset          = 1'b1;
    sif.sw_rst_req = 1'b1;
    tick(1);
    reset          = 1'b0;
    sif.sw_rst_req = 1'b0;
    check("s6_cause", 32'(sif.rst_cause), 32'h1);
    check("s6_reset", 32'(sif.stage_reset), 32'hF);
    check("s6_fault", 32'(sif.fault), 32'h0);
    check("s6_fault_stage", 32'(sif.fault_stage), 32'h0);
    check("s6_ready", 32'(sif.ready), 32'h0);
    tick(48);
    check("s6_ready_after", 32'(sif.ready), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Orders the release of per-subsystem resets in the VLC-sync FPGA. Subsystems are the ADC front-end, correlator, sync timer and host interface.
- Takes the one-cycle power-on pulse on `reset` and software reset requests.
- Holds every stage in reset, then releases stages one at a time: stage 0 first, stage N_STAGES-1 last.
- Each release waits for the previous stage's ready acknowledge.
- Flags a fault on an ack timeout or a lost ack.

Parameters:
- N_STAGES, 4, number of sequenced reset outputs (1..8).
- HOLD_CYCLES, 16, cycles all stages stay in reset before stage 0 is released (>=1).
- STAGE_GAP, 8, minimum cycles between releasing stage k and releasing stage k+1 (>=1).
- TIMEOUT, 64, maximum cycles to wait for stage_ack[k] after releasing stage k (> STAGE_GAP).
- CNT_W, 8, cycle-counter width; must hold max(HOLD_CYCLES, TIMEOUT)-1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset, e.g. the power-on pulse.
- sw_rst_req, input, 1: one-cycle software reset request.
- stage_ack, input, N_STAGES: per-stage "out of reset and ready" level.
- stage_reset, output, N_STAGES: per-stage reset, active-high.
- ready, output, 1: high when all stages are released and acknowledged.
- fault, output, 1: high when sequencing failed or an ack was lost.
- fault_stage, output, 3: index of the stage that caused the fault.
- rst_cause, output, 2: cause of the last sequence start. 01 = reset, 10 = sw_rst_req, 11 = restart out of FAULT.

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is synchronous and active-high. All outputs are registered.
- While reset=1:
  - state=HOLD, cnt=0, stage_idx=0.
  - stage_reset = all ones, ready=0, fault=0, fault_stage=0, rst_cause=01.
- Counter rule: cnt resets to 0 on every state or stage change and increments by 1 otherwise. It saturates, never wraps.
- HOLD:
  - stage_reset all ones; stage_ack ignored.
  - When cnt==HOLD_CYCLES-1: go to RELEASE with stage_idx=0, and clear stage_reset[0] at the same edge.
- RELEASE(k):
  - stage_reset[j]=0 for j<=k, 1 for j>k.
  - If cnt>=STAGE_GAP-1 and stage_ack[k]=1:
    - k<N_STAGES-1: clear stage_reset[k+1] and go to RELEASE(k+1).
    - k=N_STAGES-1: go to RUN and set ready=1 at the same edge.
  - Else, if cnt==TIMEOUT-1: go to FAULT.
  - An ack seen before STAGE_GAP-1 is held off until the gap expires. Ack pulses that drop before then are not latched.
- RUN:
  - ready=1.
  - Any stage_ack bit going low goes to FAULT, with fault_stage = lowest index whose ack is low.
- FAULT:
  - stage_reset all ones, ready=0, fault=1.
  - fault_stage holds the index of the timed-out stage (RELEASE timeout) or the lost-ack stage (RUN).
  - FAULT persists until sw_rst_req or reset.
- sw_rst_req=1, any state, reset=0:
  - Go to HOLD with cnt=0 and stage_reset all ones at the next edge. This also applies mid-sequence: the sequence restarts from stage 0.
  - ready=0 and fault=0.
  - rst_cause = 11 if coming from FAULT, else 10.
- reset has priority over sw_rst_req.
- Latency with acks tied high:
  - stage_reset[k] falls HOLD_CYCLES + k·STAGE_GAP edges after the first edge with reset low.
  - ready rises at HOLD_CYCLES + N_STAGES·STAGE_GAP edges.
- Outputs are glitch-free registers. stage_ack is treated as already synchronous to clk; crossing it in is the stage's responsibility.

Decomposition:
- Shared package reset_seq_pkg:
  - State encoding HOLD/RELEASE/RUN/FAULT (2 bits).
  - rst_cause codes RC_POR=01, RC_SW=10, RC_FAULT=11.
  - Helper function returning the lowest-zero index of an ack vector.
- The FSM, cycle counter and stage index live in a single module; no sub-module is needed.

Test Plan:
All scenarios use the default parameters.
1. Power-on: reset high 3 cycles, then low; acks tied 1 -> stage_reset[0..3] fall at edges 16/24/32/40; ready=1 at edge 48; rst_cause=01; fault=0.
2. Slow ack: stage_ack[1] rises 30 cycles after stage_reset[1] falls -> stage_reset[2] falls 1 edge later; no fault.
3. Timeout: stage_ack[2] held 0 -> FAULT 64 edges after stage_reset[2] falls; stage_reset=1111, fault=1, fault_stage=2, ready=0.
4. Lost ack in RUN: drop stage_ack[3] for 1 cycle -> fault=1, fault_stage=3, stage_reset=1111; sw_rst_req pulse -> HOLD, fault=0, rst_cause=11, ready again 48 edges later.
5. Mid-sequence sw_rst_req while in RELEASE(1) -> stage_reset=1111 next edge, rst_cause=10, full sequence replays from stage 0.
6. reset and sw_rst_req asserted in the same cycle -> rst_cause=01; outputs at reset values.
